// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch front end: enables, hold levels, reset vector
// and the PC FSM state encoding.
package pc_fetch_unit_pkg;

  localparam logic        RstEnable     = 1'b1;
  localparam logic        JumpEnable    = 1'b1;
  localparam int          Hold_Flag_Bus = 3;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Pc = 3'd1;
  localparam logic [31:0] CpuResetAddr  = 32'h0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_inst_fifo.sv
// First-word-fall-through instruction queue holding {address, instruction} pairs,
// with a synchronous flush that discards every entry at once.
module pc_inst_fifo #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [AW-1:0]            addr_o,
  output logic [DW-1:0]            data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage is deliberately not reset; only pointers/count are, and valid_o masks the head.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign valid_o          = (count_q != '0);
  assign {addr_o, data_o} = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o          = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and fetch front end: issues valid/ready fetches, queues in-order responses,
// handles jump/hold/JTAG reset. Optional macro PC_MISALIGN_CHECK_EN rejects misaligned jumps.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = CpuResetAddr,
  parameter int                PC_STEP     = 4,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                HOLD_W      = Hold_Flag_Bus,
  parameter logic [HOLD_W-1:0] HOLD_PC_LVL = Hold_Pc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              jtag_reset_flag_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              resp_valid_i,
  input  logic [DATA_W-1:0] resp_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int                SUM_W      = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_STEP - 1);
  localparam logic [SUM_W-1:0]  DEPTH_SUM  = SUM_W'(FIFO_DEPTH);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic              hold_active, jump_req, jtag_hit, jump_take, redirect;
  logic [ADDR_W-1:0] jump_target, redirect_addr;
  logic              credit_ok, req_valid, issue_fire, resp_drop;
  logic              fifo_push, fifo_pop, fifo_valid;
  logic [CNT_W-1:0]  fifo_count;

  assign hold_active = (hold_flag_i >= HOLD_PC_LVL);
  assign jump_req    = (jump_flag_i == JumpEnable);
  assign jtag_hit    = jtag_reset_flag_i;

`ifdef PC_MISALIGN_CHECK_EN
  logic              misaligned, misalign_hit;
  logic              misalign_q;
  logic [ADDR_W-1:0] misalign_addr_q;

  assign misaligned   = |(jump_addr_i & ALIGN_MASK);
  assign jump_take    = jump_req & ~misaligned & ~jtag_hit;
  assign misalign_hit = jump_req &  misaligned & ~jtag_hit;
  assign jump_target  = jump_addr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q <= misalign_hit;
      if (misalign_hit) misalign_addr_q <= jump_addr_i;
    end
  end

  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`else
  assign jump_take       = jump_req & ~jtag_hit;
  assign jump_target     = jump_addr_i & ~ALIGN_MASK;
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

  assign redirect      = jtag_hit | jump_take;
  assign redirect_addr = jtag_hit ? RESET_ADDR : jump_target;

  // Queued plus in-flight words never exceed the queue depth, so pushes can't overflow.
  assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_SUM;
  assign req_valid  = (state_q == ST_RUN) & ~hold_active & ~jump_flag_i & ~jtag_hit & credit_ok;
  assign issue_fire = req_valid & req_ready_i;

  assign resp_drop  = resp_valid_i & (redirect | (discard_q != '0));
  assign fifo_push  = resp_valid_i & ~resp_drop;
  assign fifo_pop   = fifo_valid & inst_ready_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_addr_d   = resp_addr_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(issue_fire) - CNT_W'(resp_valid_i);

    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (hold_active)  state_d = ST_STALL;
      ST_STALL: if (!hold_active) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase

    if (issue_fire)                        pc_d        = pc_q + STEP;
    if (fifo_push)                         resp_addr_d = resp_addr_q + STEP;
    if (resp_valid_i && discard_q != '0)   discard_d   = discard_q - CNT_W'(1);

    // Everything still in flight at a redirect belongs to the old stream.
    if (redirect) begin
      pc_d        = redirect_addr;
      resp_addr_d = redirect_addr;
      discard_d   = outstanding_q - CNT_W'(resp_valid_i);
    end
    if (jtag_hit) state_d = ST_BOOT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_ADDR;
      resp_addr_q   <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_addr_q   <= resp_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  pc_inst_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (fifo_push),
    .push_addr_i (resp_addr_q),
    .push_data_i (resp_data_i),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .addr_o      (inst_addr_o),
    .data_o      (inst_o),
    .count_o     (fifo_count)
  );

  assign req_valid_o  = req_valid;
  assign req_addr_o   = pc_q;
  assign inst_valid_o = fifo_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a bus model answers fetches in order, a monitor
// checks every accepted request and every delivered instruction against expected queues.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        jtag_reset_flag_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int n_checks = 0;
  int n_errors = 0;
  logic        bus_stall = 1'b0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_inst[$];
  logic [31:0] pend_q[$];

  pc_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_i       (hold_flag_i),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .req_valid_o       (req_valid_o),
    .req_addr_o        (req_addr_o),
    .req_ready_i       (req_ready_i),
    .resp_valid_i      (resp_valid_i),
    .resp_data_i       (resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .inst_ready_i      (inst_ready_i),
    .misalign_o        (misalign_o),
    .misalign_addr_o   (misalign_addr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag_error(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%08h with nothing expected", name, act);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input bit delivered);
    exp_req.push_back(a);
    if (delivered) exp_inst.push_back(a);
  endtask

  // Holds req_ready_i high until max_hs handshakes or max_cyc cycles have passed.
  task automatic issue(input int max_hs, input int max_cyc, output int got);
    int cyc = 0;
    got = 0;
    req_ready_i = 1'b1;
    while (got < max_hs && cyc < max_cyc) begin
      @(negedge clk);
      if (req_valid_o) got++;
      @(posedge clk);
      #1;
      cyc++;
    end
    req_ready_i = 1'b0;
  endtask

  // Bus model: in-order responses one cycle after acceptance, frozen while bus_stall is set.
  always @(negedge clk)
    if (!rst && req_valid_o && req_ready_i) pend_q.push_back(req_addr_o);

  initial begin
    logic [31:0] a;
    resp_valid_i = 1'b0;
    resp_data_i  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!bus_stall && pend_q.size() > 0) begin
        a = pend_q.pop_front();
        resp_valid_i = 1'b1;
        resp_data_i  = mk_data(a);
      end else begin
        resp_valid_i = 1'b0;
        resp_data_i  = '0;
      end
    end
  end

  // Monitor: compares each accepted request and each consumed instruction with the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_req.size() == 0) flag_error("req_unexpected", req_addr_o);
        else begin
          e = exp_req.pop_front();
          check("req_addr", req_addr_o, e);
        end
      end
      if (inst_valid_o && inst_ready_i) begin
        if (exp_inst.size() == 0) flag_error("inst_unexpected", inst_addr_o);
        else begin
          e = exp_inst.pop_front();
          check("inst_addr", inst_addr_o, e);
          check("inst_data", inst_o, mk_data(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    rst = 1'b1;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    hold_flag_i = '0;
    jtag_reset_flag_i = 1'b0;
    req_ready_i = 1'b0;
    inst_ready_i = 1'b1;

    // Reset state
    cycles(2);
    @(negedge clk);
    check("rst_req_valid", {31'b0, req_valid_o}, 32'h0);
    check("rst_req_addr", req_addr_o, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_inst_addr", inst_addr_o, 32'h0);
    check("rst_misalign", {31'b0, misalign_o}, 32'h0);

    // Sequential fetch after release: BOOT cycle, then 0x0, 0x4, 0x8
    @(posedge clk); #1;
    rst = 1'b0;
    req_ready_i = 1'b1;
    @(negedge clk);
    check("boot_no_req", {31'b0, req_valid_o}, 32'h0);
    @(posedge clk); #1;
    push_exp(32'h0, 1); push_exp(32'h4, 1); push_exp(32'h8, 1);
    issue(3, 20, got);
    check("seq_count", got, 3);
    cycles(5);
    check("seq_drain", exp_inst.size(), 0);

    // Credit limit: decode stalled, exactly FIFO_DEPTH requests
    inst_ready_i = 1'b0;
    push_exp(32'hC, 1); push_exp(32'h10, 1); push_exp(32'h14, 1); push_exp(32'h18, 1);
    issue(99, 12, got);
    check("credit_count", got, 4);
    @(negedge clk);
    check("credit_blocked", {31'b0, req_valid_o}, 32'h0);
    check("credit_head_valid", {31'b0, inst_valid_o}, 32'h1);
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    @(negedge clk);
    check("credit_still_blocked", {31'b0, req_valid_o}, 32'h0);
    @(posedge clk); #1;
    inst_ready_i = 1'b0;
    @(negedge clk);
    check("credit_reopened", {31'b0, req_valid_o}, 32'h1);
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    cycles(5);
    check("credit_drain", exp_inst.size(), 0);

    // Jump to 0x100 with two fetches in flight: both responses dropped
    bus_stall = 1'b1;
    push_exp(32'h1C, 0); push_exp(32'h20, 0);
    issue(2, 20, got);
    check("jump_pre_count", got, 2);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    @(posedge clk); #1;
    jump_flag_i = 1'b0;
    bus_stall = 1'b0;
    @(negedge clk);
    check("jump_pc", req_addr_o, 32'h100);
    @(posedge clk); #1;
    push_exp(32'h100, 1); push_exp(32'h104, 1);
    issue(2, 20, got);
    check("jump_post_count", got, 2);
    cycles(6);
    check("jump_drain", exp_inst.size(), 0);

    // Hold for 5 cycles with two words queued: no fetch, pc frozen, queue drains
    inst_ready_i = 1'b0;
    push_exp(32'h108, 1); push_exp(32'h10C, 1);
    issue(2, 20, got);
    cycles(3);
    hold_flag_i = 3'd1;
    req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_valid_o) got++;
      check("hold_pc", req_addr_o, 32'h110);
      @(posedge clk); #1;
    end
    hold_flag_i = 3'd0;
    req_ready_i = 1'b0;
    check("hold_no_req", got, 0);
    @(negedge clk);
    check("hold_drained", {31'b0, inst_valid_o}, 32'h0);
    @(posedge clk); #1;

    // JTAG reset together with jump to 0x200: queued and in-flight words discarded
    inst_ready_i = 1'b0;
    push_exp(32'h110, 0);
    issue(1, 20, got);
    cycles(3);
    bus_stall = 1'b1;
    push_exp(32'h114, 0);
    issue(1, 20, got);
    jtag_reset_flag_i = 1'b1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h200;
    @(negedge clk);
    check("jtag_pre_queued", {31'b0, inst_valid_o}, 32'h1);
    @(posedge clk); #1;
    jtag_reset_flag_i = 1'b0;
    jump_flag_i = 1'b0;
    req_ready_i = 1'b1;
    bus_stall = 1'b0;
    inst_ready_i = 1'b1;
    @(negedge clk);
    check("jtag_pc", req_addr_o, 32'h0);
    check("jtag_flushed", {31'b0, inst_valid_o}, 32'h0);
    check("jtag_boot_no_req", {31'b0, req_valid_o}, 32'h0);
    @(posedge clk); #1;
    push_exp(32'h0, 1);
    issue(1, 20, got);
    check("jtag_post_count", got, 1);
    cycles(5);

    // Aligned jump to 0x100, then jump to 0x102
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    @(posedge clk); #1;
    jump_addr_i = 32'h102;
    @(posedge clk); #1;
    jump_flag_i = 1'b0;
    @(negedge clk);
    check("mis_pc", req_addr_o, 32'h100);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_pulse", {31'b0, misalign_o}, 32'h1);
    check("mis_addr", misalign_addr_o, 32'h102);
`else
    check("mis_pulse_off", {31'b0, misalign_o}, 32'h0);
    check("mis_addr_off", misalign_addr_o, 32'h0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_pulse_end", {31'b0, misalign_o}, 32'h0);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_addr_held", misalign_addr_o, 32'h102);
`else
    check("mis_addr_held_off", misalign_addr_o, 32'h0);
`endif
    @(posedge clk); #1;
    push_exp(32'h100, 1);
    issue(1, 20, got);
    check("mis_post_count", got, 1);
    cycles(6);

    check("final_req_sb", exp_req.size(), 0);
    check("final_inst_sb", exp_inst.size(), 0);
    check("final_bus_idle", pend_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
